// File: rtl/sram_port_arbiter_pkg.sv
// Shared IDs, default sizing and the request payload for sram_port_arbiter.
package sram_port_arbiter_pkg;

  localparam int unsigned ARB_ID_WD        = 1;
  localparam logic [ARB_ID_WD-1:0] ARB_ID_M0 = 1'b0;
  localparam logic [ARB_ID_WD-1:0] ARB_ID_M1 = 1'b1;
  localparam int unsigned OT_DEPTH_DEFAULT = 4;

  localparam int unsigned SIZE_W  = 2;
  localparam int unsigned WSTRB_W = 4;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;

  typedef struct packed {
    logic               wr;
    logic [SIZE_W-1:0]  size;
    logic [WSTRB_W-1:0] wstrb;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  wdata;
  } sram_req_t;

endpackage

// File: rtl/sram_port_arbiter_arb_id_fifo.sv
// In-order owner-ID queue: synchronous push/pop, async active-low reset.
module arb_id_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WD    = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WD-1:0]                din,
  output logic [WD-1:0]                head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WD-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-master to one-slave SRAM-like arbiter with address-phase grant lock and in-order response routing.
// Optional round-robin arbitration when ARB_ROUND_ROBIN_EN is defined (default: m1 over m0).
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int unsigned OT_DEPTH = OT_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [1:0]  m0_size,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_addr_ok,
  output logic        m0_data_ok,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [1:0]  m1_size,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_addr_ok,
  output logic        m1_data_ok,
  output logic [31:0] m1_rdata,
  output logic        s_req,
  output logic        s_wr,
  output logic [1:0]  s_size,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_addr_ok,
  input  logic        s_data_ok,
  input  logic [31:0] s_rdata,
  output logic        busy,
  output logic        err_spurious
);

  localparam int unsigned CW = $clog2(OT_DEPTH + 1);
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [ARB_ID_WD-1:0] lock_id_q, lock_id_d;
  logic                 lock;
  logic                 err_q;

  logic                 gnt_vld;
  logic [ARB_ID_WD-1:0] gnt_id;
  logic                 gnt_req;
  sram_req_t            m0_pl, m1_pl, s_pl;

  logic                 push, pop;
  logic [ARB_ID_WD-1:0] head;
  logic [CW-1:0]        count;
  logic                 full, empty;

`ifdef ARB_ROUND_ROBIN_EN
  logic [ARB_ID_WD-1:0] last_id_q;

  // Remember the most recently accepted owner to alternate on contention.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)   last_id_q <= ARB_ID_M0;
    else if (push) last_id_q <= gnt_id;
  end
`endif

  assign lock  = (state_q == ST_LOCKED);
  assign m0_pl = {m0_wr, m0_size, m0_wstrb, m0_addr, m0_wdata};
  assign m1_pl = {m1_wr, m1_size, m1_wstrb, m1_addr, m1_wdata};

  // Grant selection; a full queue or reset blocks every grant, a lock pins it.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = ARB_ID_M0;
    if (resetn && !full) begin
      if (lock) begin
        gnt_vld = 1'b1;
        gnt_id  = lock_id_q;
      end else if (m0_req && m1_req) begin
        gnt_vld = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        gnt_id  = ~last_id_q;
`else
        gnt_id  = ARB_ID_M1;
`endif
      end else if (m1_req) begin
        gnt_vld = 1'b1;
        gnt_id  = ARB_ID_M1;
      end else if (m0_req) begin
        gnt_vld = 1'b1;
        gnt_id  = ARB_ID_M0;
      end
    end
  end

  always_comb begin
    gnt_req = 1'b0;
    s_pl    = '0;
    if (gnt_vld) begin
      gnt_req = (gnt_id == ARB_ID_M1) ? m1_req : m0_req;
      s_pl    = (gnt_id == ARB_ID_M1) ? m1_pl  : m0_pl;
    end
  end

  assign s_req   = gnt_vld & gnt_req;
  assign s_wr    = s_pl.wr;
  assign s_size  = s_pl.size;
  assign s_wstrb = s_pl.wstrb;
  assign s_addr  = s_pl.addr;
  assign s_wdata = s_pl.wdata;

  assign m0_addr_ok = gnt_vld & (gnt_id == ARB_ID_M0) & s_addr_ok;
  assign m1_addr_ok = gnt_vld & (gnt_id == ARB_ID_M1) & s_addr_ok;

  // Lock FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      lock_id_q <= ARB_ID_M0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
    end
  end

  // Lock FSM next state: hold the grant while the slave stalls the address phase.
  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    case (state_q)
      ST_IDLE: begin
        if (s_req && !s_addr_ok) begin
          state_d   = ST_LOCKED;
          lock_id_d = gnt_id;
        end
      end
      ST_LOCKED: begin
        if (s_addr_ok) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign push = s_req & s_addr_ok;
  assign pop  = s_data_ok & ~empty;

  arb_id_fifo #(
    .DEPTH (OT_DEPTH),
    .WD    (ARB_ID_WD)
  ) u_id_fifo (
    .clk   (clk),
    .rst_n (resetn),
    .push  (push),
    .pop   (pop),
    .din   (gnt_id),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign m0_data_ok = pop & (head == ARB_ID_M0);
  assign m1_data_ok = pop & (head == ARB_ID_M1);
  assign m0_rdata   = s_rdata;
  assign m1_rdata   = s_rdata;

  // Sticky flag for a response that has no outstanding owner.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                 err_q <= 1'b0;
    else if (s_data_ok && empty) err_q <= 1'b1;
  end

  assign err_spurious = err_q;
  assign busy         = (count != '0) | lock;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed self-checking bench for sram_port_arbiter (default fixed-priority build, OT_DEPTH=4).
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [1:0]  m0_size, m1_size, s_size;
  logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_req, s_wr, s_addr_ok, s_data_ok;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic        busy, err_spurious;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.OT_DEPTH(4)) dut (
    .clk(clk), .resetn(resetn),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_wstrb(m0_wstrb),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_addr_ok(m0_addr_ok),
    .m0_data_ok(m0_data_ok), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_wstrb(m1_wstrb),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_addr_ok(m1_addr_ok),
    .m1_data_ok(m1_data_ok), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_addr_ok(s_addr_ok),
    .s_data_ok(s_data_ok), .s_rdata(s_rdata),
    .busy(busy), .err_spurious(err_spurious)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge, then inputs may be changed.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling.
  task automatic settle();
    #2;
  endtask

  initial begin
    resetn = 1'b0;
    m0_req = 0; m0_wr = 0; m0_size = 2'd2; m0_wstrb = 4'h0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_wr = 0; m1_size = 2'd2; m1_wstrb = 4'h0; m1_addr = '0; m1_wdata = '0;
    s_addr_ok = 0; s_data_ok = 0; s_rdata = '0;

    // Reset state: requests are ignored while reset is low
    m0_req = 1'b1; m0_addr = 32'h1C00_0000; s_addr_ok = 1'b1;
    settle();
    check("rst_s_req", 32'(s_req), 32'd0);
    check("rst_s_addr", s_addr, 32'h0);
    check("rst_m0_addr_ok", 32'(m0_addr_ok), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err_spurious), 32'd0);
    m0_req = 1'b0; s_addr_ok = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    tick();

    // Single m0 read
    m0_req = 1'b1; m0_addr = 32'h1C00_0000; s_addr_ok = 1'b1;
    settle();
    check("rd_s_req", 32'(s_req), 32'd1);
    check("rd_s_addr", s_addr, 32'h1C00_0000);
    check("rd_m0_addr_ok", 32'(m0_addr_ok), 32'd1);
    check("rd_m1_addr_ok", 32'(m1_addr_ok), 32'd0);
    tick();
    m0_req = 1'b0; s_addr_ok = 1'b0;
    settle();
    check("rd_busy", 32'(busy), 32'd1);
    tick();
    tick();
    s_data_ok = 1'b1; s_rdata = 32'h1234_5678;
    settle();
    check("rd_m0_data_ok", 32'(m0_data_ok), 32'd1);
    check("rd_m1_data_ok", 32'(m1_data_ok), 32'd0);
    check("rd_m0_rdata", m0_rdata, 32'h1234_5678);
    tick();
    s_data_ok = 1'b0;
    settle();
    check("rd_idle_busy", 32'(busy), 32'd0);

    // Contention: m1 first, m0 next cycle, responses in the same order
    tick();
    m0_req = 1'b1; m0_addr = 32'h1C00_0010;
    m1_req = 1'b1; m1_wr = 1'b1; m1_wstrb = 4'hF; m1_addr = 32'h0000_2000; m1_wdata = 32'hCAFE_F00D;
    s_addr_ok = 1'b1;
    settle();
    check("ct1_s_addr", s_addr, 32'h0000_2000);
    check("ct1_s_wr", 32'(s_wr), 32'd1);
    check("ct1_s_wdata", s_wdata, 32'hCAFE_F00D);
    check("ct1_s_wstrb", 32'(s_wstrb), 32'hF);
    check("ct1_m1_addr_ok", 32'(m1_addr_ok), 32'd1);
    check("ct1_m0_addr_ok", 32'(m0_addr_ok), 32'd0);
    tick();
    m1_req = 1'b0; m1_wr = 1'b0;
    settle();
    check("ct2_s_addr", s_addr, 32'h1C00_0010);
    check("ct2_s_wr", 32'(s_wr), 32'd0);
    check("ct2_m0_addr_ok", 32'(m0_addr_ok), 32'd1);
    tick();
    m0_req = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b1; s_rdata = 32'h0000_0001;
    settle();
    check("ct3_m1_data_ok", 32'(m1_data_ok), 32'd1);
    check("ct3_m0_data_ok", 32'(m0_data_ok), 32'd0);
    tick();
    s_rdata = 32'h0000_0002;
    settle();
    check("ct4_m0_data_ok", 32'(m0_data_ok), 32'd1);
    check("ct4_m1_data_ok", 32'(m1_data_ok), 32'd0);
    tick();
    s_data_ok = 1'b0;

    // Lock hold: addr_ok low for 3 cycles while m0 is granted
    m0_req = 1'b1; m0_addr = 32'h1C00_0100;
    settle();
    check("lk0_s_addr", s_addr, 32'h1C00_0100);
    tick();
    m1_req = 1'b1; m1_addr = 32'h0000_3000;
    settle();
    check("lk1_s_addr", s_addr, 32'h1C00_0100);
    check("lk1_busy", 32'(busy), 32'd1);
    tick();
    settle();
    check("lk2_s_addr", s_addr, 32'h1C00_0100);
    tick();
    s_addr_ok = 1'b1;
    settle();
    check("lk3_m0_addr_ok", 32'(m0_addr_ok), 32'd1);
    check("lk3_m1_addr_ok", 32'(m1_addr_ok), 32'd0);
    tick();
    m0_req = 1'b0;
    settle();
    check("lk4_s_addr", s_addr, 32'h0000_3000);
    check("lk4_m1_addr_ok", 32'(m1_addr_ok), 32'd1);
    tick();
    m1_req = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b1;
    settle();
    check("lk5_m0_data_ok", 32'(m0_data_ok), 32'd1);
    tick();
    settle();
    check("lk6_m1_data_ok", 32'(m1_data_ok), 32'd1);
    tick();
    s_data_ok = 1'b0;

    // Full queue: four accepted, fifth blocked until one response drains
    m0_req = 1'b1; m0_addr = 32'h1C00_0200; s_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    settle();
    check("full_s_req", 32'(s_req), 32'd0);
    check("full_m0_addr_ok", 32'(m0_addr_ok), 32'd0);
    tick();
    s_data_ok = 1'b1;
    settle();
    check("full_pop_s_req", 32'(s_req), 32'd0);
    check("full_pop_m0_data_ok", 32'(m0_data_ok), 32'd1);
    tick();
    s_data_ok = 1'b0;
    settle();
    check("full_refill_s_req", 32'(s_req), 32'd1);
    check("full_refill_addr_ok", 32'(m0_addr_ok), 32'd1);
    tick();
    m0_req = 1'b0; s_addr_ok = 1'b0; m1_req = 1'b1; m1_addr = 32'h0000_4000;
    settle();
    check("full_again_s_req", 32'(s_req), 32'd0);
    tick();
    m1_req = 1'b0; s_data_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("full_drain_m0_data_ok", 32'(m0_data_ok), 32'd1);
      tick();
    end
    s_data_ok = 1'b0;
    settle();
    check("full_drained_busy", 32'(busy), 32'd0);

    // Spurious response with the queue empty
    check("sp_err_before", 32'(err_spurious), 32'd0);
    tick();
    s_data_ok = 1'b1;
    settle();
    check("sp_m0_data_ok", 32'(m0_data_ok), 32'd0);
    check("sp_m1_data_ok", 32'(m1_data_ok), 32'd0);
    tick();
    s_data_ok = 1'b0;
    settle();
    check("sp_err_set", 32'(err_spurious), 32'd1);
    tick(); tick();
    check("sp_err_sticky", 32'(err_spurious), 32'd1);

    // Reset mid-operation: three outstanding m0 reads and a locked m1
    m0_req = 1'b1; m0_addr = 32'h1C00_0300; s_addr_ok = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    m0_req = 1'b0; s_addr_ok = 1'b0; m1_req = 1'b1; m1_addr = 32'h0000_5000;
    tick();
    settle();
    check("mr_busy_before", 32'(busy), 32'd1);
    resetn = 1'b0; s_data_ok = 1'b1;
    settle();
    check("mr_s_req", 32'(s_req), 32'd0);
    check("mr_s_addr", s_addr, 32'h0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_err", 32'(err_spurious), 32'd0);
    check("mr_m0_data_ok", 32'(m0_data_ok), 32'd0);
    m1_req = 1'b0; s_data_ok = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    m1_req = 1'b1; m1_wr = 1'b1; m1_wstrb = 4'h3; m1_addr = 32'h0000_6000; m1_wdata = 32'hA5A5_5A5A;
    s_addr_ok = 1'b1;
    settle();
    check("mr_wr_s_req", 32'(s_req), 32'd1);
    check("mr_wr_s_wr", 32'(s_wr), 32'd1);
    check("mr_wr_s_wdata", s_wdata, 32'hA5A5_5A5A);
    check("mr_wr_m1_addr_ok", 32'(m1_addr_ok), 32'd1);
    tick();
    m1_req = 1'b0; m1_wr = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b1;
    settle();
    check("mr_wr_m1_data_ok", 32'(m1_data_ok), 32'd1);
    check("mr_wr_m0_data_ok", 32'(m0_data_ok), 32'd0);
    tick();
    s_data_ok = 1'b0;
    settle();
    check("mr_end_busy", 32'(busy), 32'd0);
    check("mr_end_err", 32'(err_spurious), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
